// File: rtl/md_cart_pkg.sv
// Shared types and helpers for the cartridge-side bus bridge.
//   cart_state_t  : bridge FSM states
//   cache_entry_t : one cached (or prefetched) memory word
//   patch_word()  : merge write data into a cached word under byte enables
//   in_window()   : word-address window compare against a 2^n aligned base
package md_cart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MISS = 3'd1,
        RD_HOLD = 3'd2,
        WR_REQ  = 3'd3,
        WR_HOLD = 3'd4,
        PF_REQ  = 3'd5
    } cart_state_t;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
        logic        valid;
    } cache_entry_t;

    function automatic logic [15:0] patch_word(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  be);
        patch_word = {be[1] ? new_w[15:8] : old_w[15:8],
                      be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

    // True when addr and base agree on every bit above the window size.
    function automatic logic in_window(input logic [22:0] addr,
                                       input logic [22:0] base,
                                       input int unsigned log2);
        in_window = ((addr ^ base) >> log2) == 23'd0;
    endfunction

endpackage

// File: rtl/md_cart_bridge_if.sv
// Word-memory request/acknowledge bus between the cart bridge and the
// external ROM/SRAM store.
//   mem_req   : level request, held until mem_ack
//   mem_we    : 1 = write
//   mem_addr  : word address
//   mem_be    : byte enables {upper, lower}
//   mem_wdata : write data
//   mem_ack   : one-cycle completion pulse
//   mem_rdata : read data, valid with mem_ack
// master = bridge side, slave = memory side.
interface md_cart_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/md_cart_edge.sv
// Registered rising-edge detector for the cart read and write strobe
// combinations. Each start output is a one-cycle pulse, one cycle after
// the level is first sampled high.
//   MCLK2     : board clock
//   ext_reset : synchronous active-high reset
//   rd_lvl    : cart_cs & cart_oe
//   wr_lvl    : cart_cs & (cart_lwr | cart_uwr)
//   rd_start  : rising edge of rd_lvl
//   wr_start  : rising edge of wr_lvl
module md_cart_edge (
    input  logic MCLK2,
    input  logic ext_reset,
    input  logic rd_lvl,
    input  logic wr_lvl,
    output logic rd_start,
    output logic wr_start
);
    logic rd_q;
    logic wr_q;

    always_ff @(posedge MCLK2) begin
        if (ext_reset) begin
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_start <= 1'b0;
            wr_start <= 1'b0;
        end else begin
            rd_q     <= rd_lvl;
            wr_q     <= wr_lvl;
            rd_start <= rd_lvl & ~rd_q;
            wr_start <= wr_lvl & ~wr_q;
        end
    end
endmodule

// File: rtl/md_cart_bridge.sv
// Cartridge-side bridge: decodes cart strobes, serves ROM/SRAM words from
// an external word memory through a one-word cache, writes the SRAM window
// and drives the external DTACK for SRAM-window accesses.
//
// Optional build macro MD_CART_PREFETCH_EN: after a non-SRAM read the next
// sequential word is fetched into a prefetch entry.
//
// Ports:
//   MCLK2        in   board clock, posedge
//   ext_reset    in   synchronous active-high reset
//   cart_address in   68k word address (A23:A1)
//   cart_cs      in   chip select
//   cart_oe      in   read strobe
//   cart_lwr     in   low-byte write strobe
//   cart_uwr     in   high-byte write strobe
//   cart_data_wr in   write data
//   cart_data    out  read data
//   cart_data_en out  read data valid
//   ext_dtack    out  force board DTACK (SRAM window only)
//   mem          if   word-memory master port
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a read or write strobe edge
// RD_MISS | read request outstanding to memory
// RD_HOLD | read data on the bus until the read strobe falls
// WR_REQ  | SRAM write request outstanding to memory
// WR_HOLD | write done or discarded, waiting for the write strobes to fall
// PF_REQ  | sequential prefetch outstanding (prefetch build only)
module md_cart_bridge
    import md_cart_pkg::*;
#(
    parameter logic [22:0] SRAM_BASE       = 23'h100000,
    parameter int unsigned SRAM_WORDS_LOG2 = 15,
    parameter bit          SRAM_EN         = 1'b1
) (
    input  logic              MCLK2,
    input  logic              ext_reset,
    input  logic [22:0]       cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    input  logic              cart_lwr,
    input  logic              cart_uwr,
    input  logic [15:0]       cart_data_wr,
    output logic [15:0]       cart_data,
    output logic              cart_data_en,
    output logic              ext_dtack,
    md_cart_bridge_if.master  mem
);

    cart_state_t  state;
    cache_entry_t cache;
    logic         acc_sram;
    logic         rd_lvl, wr_lvl;
    logic         rd_start, wr_start;
    logic         rd_go;
    logic         addr_in_sram;
    logic         cache_hit;
    logic         pf_hit;

    assign rd_lvl       = cart_cs & cart_oe;
    assign wr_lvl       = cart_cs & (cart_lwr | cart_uwr);
    assign addr_in_sram = SRAM_EN && in_window(cart_address, SRAM_BASE, SRAM_WORDS_LOG2);
    assign cache_hit    = cache.valid && (cache.addr == cart_address);

    md_cart_edge u_edge (
        .MCLK2    (MCLK2),
        .ext_reset(ext_reset),
        .rd_lvl   (rd_lvl),
        .wr_lvl   (wr_lvl),
        .rd_start (rd_start),
        .wr_start (wr_start)
    );

`ifdef MD_CART_PREFETCH_EN
    cache_entry_t pf;
    logic [22:0]  acc_addr;
    logic         rd_pend;

    assign pf_hit = pf.valid && (pf.addr == cart_address);
    // A read that arrived while a prefetch was in flight is replayed once
    // the bridge is back in IDLE, provided its strobe is still up.
    assign rd_go  = rd_start | (rd_pend & rd_lvl);
`else
    assign pf_hit = 1'b0;
    assign rd_go  = rd_start;
`endif

    always_ff @(posedge MCLK2) begin
        if (ext_reset) begin
            state         <= IDLE;
            cache         <= '0;
            acc_sram      <= 1'b0;
            cart_data     <= '0;
            cart_data_en  <= 1'b0;
            ext_dtack     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
`ifdef MD_CART_PREFETCH_EN
            pf            <= '0;
            acc_addr      <= '0;
            rd_pend       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MD_CART_PREFETCH_EN
                    rd_pend <= 1'b0;
`endif
                    // Write wins over a read starting in the same cycle.
                    // Byte enables are sampled one cycle after the first
                    // strobe edge, so a late second byte strobe is merged.
                    if (wr_start) begin
                        if (addr_in_sram) begin
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= cart_address;
                            mem.mem_be    <= {cart_uwr, cart_lwr};
                            mem.mem_wdata <= cart_data_wr;
                            state         <= WR_REQ;
                        end else begin
                            state <= WR_HOLD;
                        end
                    end else if (rd_go) begin
                        acc_sram <= addr_in_sram;
`ifdef MD_CART_PREFETCH_EN
                        acc_addr <= cart_address;
`endif
                        if (cache_hit) begin
                            cart_data    <= cache.data;
                            cart_data_en <= 1'b1;
                            ext_dtack    <= addr_in_sram;
                            state        <= RD_HOLD;
                        end
`ifdef MD_CART_PREFETCH_EN
                        else if (pf_hit) begin
                            cart_data    <= pf.data;
                            cart_data_en <= 1'b1;
                            ext_dtack    <= addr_in_sram;
                            cache        <= pf;
                            pf.valid     <= 1'b0;
                            state        <= RD_HOLD;
                        end
`endif
                        else begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_be   <= 2'b11;
                            mem.mem_addr <= cart_address;
                            state        <= RD_MISS;
                        end
                    end
                end

                RD_MISS: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        cache       <= '{addr: mem.mem_addr, data: mem.mem_rdata, valid: 1'b1};
                        // An abandoned read still fills the cache but never
                        // drives the bus.
                        if (rd_lvl) begin
                            cart_data    <= mem.mem_rdata;
                            cart_data_en <= 1'b1;
                            ext_dtack    <= acc_sram;
                            state        <= RD_HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                RD_HOLD: begin
                    if (!rd_lvl) begin
                        cart_data_en <= 1'b0;
                        ext_dtack    <= 1'b0;
`ifdef MD_CART_PREFETCH_EN
                        if (!acc_sram) begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_be   <= 2'b11;
                            mem.mem_addr <= acc_addr + 23'd1;
                            state        <= PF_REQ;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end

                WR_REQ: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        ext_dtack   <= 1'b1;
                        if (cache.valid && cache.addr == mem.mem_addr)
                            cache.data <= patch_word(cache.data, mem.mem_wdata, mem.mem_be);
`ifdef MD_CART_PREFETCH_EN
                        if (pf.valid && pf.addr == mem.mem_addr)
                            pf.data <= patch_word(pf.data, mem.mem_wdata, mem.mem_be);
`endif
                        state <= WR_HOLD;
                    end
                end

                WR_HOLD: begin
                    if (!wr_lvl) begin
                        ext_dtack <= 1'b0;
                        state     <= IDLE;
                    end
                end

`ifdef MD_CART_PREFETCH_EN
                PF_REQ: begin
                    if (rd_start)
                        rd_pend <= 1'b1;
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        pf          <= '{addr: mem.mem_addr, data: mem.mem_rdata, valid: 1'b1};
                        state       <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_cart_bridge.sv
module tb_md_cart_bridge;

`ifdef MD_CART_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        MCLK2 = 1'b0;
    logic        ext_reset;
    logic [22:0] cart_address;
    logic        cart_cs, cart_oe, cart_lwr, cart_uwr;
    logic [15:0] cart_data_wr;
    logic [15:0] cart_data;
    logic        cart_data_en;
    logic        ext_dtack;

    md_cart_bridge_if mem_if ();

    md_cart_bridge dut (
        .MCLK2        (MCLK2),
        .ext_reset    (ext_reset),
        .cart_address (cart_address),
        .cart_cs      (cart_cs),
        .cart_oe      (cart_oe),
        .cart_lwr     (cart_lwr),
        .cart_uwr     (cart_uwr),
        .cart_data_wr (cart_data_wr),
        .cart_data    (cart_data),
        .cart_data_en (cart_data_en),
        .ext_dtack    (ext_dtack),
        .mem          (mem_if)
    );

    always #5 MCLK2 = ~MCLK2;

    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 5;
    int          ack_count = 0;
    int          wait_cnt = 0;
    time         ack_time = 0;
    bit          en_seen, dtack_seen;
    logic        cap_we;
    logic [1:0]  cap_be;
    logic [22:0] cap_addr;
    logic [15:0] cap_wdata;
    logic [15:0] mem_model [logic [22:0]];

    typedef struct {
        bit          is_wr;
        logic [22:0] addr;
        logic [15:0] data;
        logic        u;
        logic        l;
        bit          exp_flag;   // read: expect hit; write: expect request
        logic [15:0] exp_d;
        logic [1:0]  exp_be;
        bit          exp_dtack;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        return mem_model.exists(a) ? mem_model[a] : 16'h0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK2);
        #1;
    endtask

    // Memory responder and bus monitor, acting on the falling edge.
    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0;
        forever begin
            @(negedge MCLK2);
            en_seen    |= cart_data_en;
            dtack_seen |= ext_dtack;
            if (mem_if.mem_ack) begin
                mem_if.mem_ack = 1'b0;
                wait_cnt = 0;
            end else if (mem_if.mem_req) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    cap_we    = mem_if.mem_we;
                    cap_be    = mem_if.mem_be;
                    cap_addr  = mem_if.mem_addr;
                    cap_wdata = mem_if.mem_wdata;
                    if (mem_if.mem_we) begin
                        logic [15:0] old_w;
                        old_w = mem_rd(mem_if.mem_addr);
                        mem_model[mem_if.mem_addr] =
                            {mem_if.mem_be[1] ? mem_if.mem_wdata[15:8] : old_w[15:8],
                             mem_if.mem_be[0] ? mem_if.mem_wdata[7:0]  : old_w[7:0]};
                    end else begin
                        mem_if.mem_rdata = mem_rd(mem_if.mem_addr);
                    end
                    mem_if.mem_ack = 1'b1;
                    ack_count++;
                    ack_time = $time;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 40 && mem_if.mem_req; n++) tick();
        tick();
    endtask

    task automatic do_read(input string nm, input logic [22:0] a, input bit exp_hit,
                           input logic [15:0] exp_d, input bit exp_dtack);
        int base;
        int n;
        bit seen;
        base = ack_count;
        n = 0;
        seen = 1'b0;
        dtack_seen = 1'b0;
        cart_address = a;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = cart_data_en;
        end
        check({nm, " en"}, 32'(seen), 32'd1);
        check({nm, " data"}, 32'(cart_data), 32'(exp_d));
        check({nm, " dtack"}, 32'(ext_dtack), 32'(exp_dtack));
        if (exp_hit) begin
            check({nm, " hit latency"}, 32'(n), 32'd2);
            check({nm, " req count"}, 32'(ack_count - base), 32'd0);
        end else begin
            check({nm, " req count"}, 32'(ack_count - base), 32'd1);
            check({nm, " ack to en"}, 32'($time - ack_time), 32'd6);
            check({nm, " req fields"}, {8'h0, cap_we, cap_be, cap_addr}, {8'h0, 1'b0, 2'b11, a});
        end
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        tick();
        check({nm, " en off"}, 32'(cart_data_en), 32'd0);
        check({nm, " dtack seen"}, 32'(dtack_seen | ext_dtack), 32'(exp_dtack));
        wait_idle();
    endtask

    task automatic do_write(input string nm, input logic [22:0] a, input logic [15:0] d,
                            input logic u, input logic l, input bit late_u, input logic oe,
                            input bit exp_req, input logic [1:0] exp_be);
        int base;
        bit got;
        base = ack_count;
        got = 1'b0;
        en_seen = 1'b0;
        dtack_seen = 1'b0;
        cart_address = a;
        cart_data_wr = d;
        cart_cs = 1'b1;
        cart_oe = oe;
        cart_lwr = l;
        cart_uwr = u;
        if (late_u) begin
            tick();
            cart_uwr = 1'b1;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = (ack_count != base);
        end
        check({nm, " req issued"}, 32'(got), 32'(exp_req));
        if (exp_req) begin
            check({nm, " we/be/addr"}, {8'h0, cap_we, cap_be, cap_addr}, {8'h0, 1'b1, exp_be, a});
            check({nm, " wdata"}, 32'(cap_wdata), 32'(d));
            check({nm, " dtack at ack"}, 32'(ext_dtack), 32'd1);
            tick();
            check({nm, " dtack held"}, 32'(ext_dtack), 32'd1);
        end else begin
            check({nm, " dtack never"}, 32'(dtack_seen | ext_dtack), 32'd0);
        end
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        cart_lwr = 1'b0;
        cart_uwr = 1'b0;
        tick();
        check({nm, " dtack off"}, 32'(ext_dtack), 32'd0);
        check({nm, " no read data"}, 32'(en_seen), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit got;
        ext_reset = 1'b1;
        cart_address = '0;
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        cart_lwr = 1'b0;
        cart_uwr = 1'b0;
        cart_data_wr = '0;

        mem_model[23'h000100] = 16'hA55A;
        mem_model[23'h000101] = 16'h1234;
        mem_model[23'h100004] = 16'h1200;
        mem_model[23'h7fffff] = 16'h7777;
        mem_model[23'h000000] = 16'h0F0F;
        mem_model[23'h000200] = 16'h4444;
        mem_model[23'h000300] = 16'h3333;

        //            wr    addr         data     u     l     flag  exp_d     be     dtack
        vecs[0]  = '{1'b0, 23'h000100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA55A, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 23'h000100, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA55A, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 23'h000101, 16'h0000, 1'b0, 1'b0, PF,   16'h1234, 2'b00, 1'b0};
        vecs[3]  = '{1'b0, 23'h000101, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 23'h100004, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0000, 2'b01, 1'b1};
        vecs[5]  = '{1'b0, 23'h100004, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h12EF, 2'b00, 1'b1};
        vecs[6]  = '{1'b1, 23'h100004, 16'h5A00, 1'b1, 1'b0, 1'b1, 16'h0000, 2'b10, 1'b1};
        vecs[7]  = '{1'b0, 23'h100004, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5AEF, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 23'h000010, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 23'h7fffff, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h7777, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 23'h000000, 16'h0000, 1'b0, 1'b0, PF,   16'h0F0F, 2'b00, 1'b0};
        vecs[11] = '{1'b1, 23'h1000FF, 16'hCAFE, 1'b1, 1'b1, 1'b1, 16'h0000, 2'b11, 1'b1};

        tick();
        tick();
        tick();
        check("reset cart outputs", {14'h0, cart_data_en, ext_dtack, cart_data}, 32'h0);
        check("reset mem ctl", {28'h0, mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}, 32'h0);
        check("reset mem addr", 32'(mem_if.mem_addr), 32'h0);
        ext_reset = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr)
                do_write($sformatf("v%0d wr", i), vecs[i].addr, vecs[i].data, vecs[i].u,
                         vecs[i].l, 1'b0, 1'b0, vecs[i].exp_flag, vecs[i].exp_be);
            else
                do_read($sformatf("v%0d rd", i), vecs[i].addr, vecs[i].exp_flag,
                        vecs[i].exp_d, vecs[i].exp_dtack);
        end

        // Reset while a read miss is outstanding.
        ack_delay = 50;
        base = ack_count;
        cart_address = 23'h000200;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            got = mem_if.mem_req;
        end
        check("rst miss req up", 32'(got), 32'd1);
        ext_reset = 1'b1;
        tick();
        check("rst req dropped", 32'(mem_if.mem_req), 32'd0);
        check("rst cart outputs", {14'h0, cart_data_en, ext_dtack, cart_data}, 32'h0);
        check("rst mem fields", {6'h0, mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr}, 32'h0);
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        tick();
        ext_reset = 1'b0;
        tick();
        tick();
        check("rst no ack", 32'(ack_count - base), 32'd0);
        ack_delay = 5;
        do_read("post-reset rd 0", 23'h000000, 1'b0, 16'h0F0F, 1'b0);

        // Read strobe dropped before the miss completes.
        ack_delay = 8;
        base = ack_count;
        cart_address = 23'h000300;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            got = mem_if.mem_req;
        end
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        en_seen = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = (ack_count != base);
        end
        check("abandon ack", 32'(got), 32'd1);
        tick();
        tick();
        check("abandon en stays 0", 32'(en_seen | cart_data_en), 32'd0);
        check("abandon req low", 32'(mem_if.mem_req), 32'd0);
        ack_delay = 5;
        do_read("abandon then hit", 23'h000300, 1'b1, 16'h3333, 1'b0);

        // Read and write strobes rising together: the write wins.
        do_write("rd+wr", 23'h100010, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        do_read("rd after rd+wr", 23'h100010, 1'b0, 16'h0011, 1'b1);

        // Upper byte strobe rising one cycle after the lower one.
        do_write("widen", 23'h100020, 16'hA1B2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        do_read("rd widened", 23'h100020, 1'b0, 16'hA1B2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_cart_bridge.md
Name: md_cart_bridge

Overview:
- Cartridge-side stage feeding the board's cart port. It decodes the board's cart strobes and addresses.
- It serves ROM/SRAM words from an external word memory through a req/ack handshake. It returns them on cart_data with cart_data_en.
- A one-word cache plus optional sequential prefetch hides memory latency inside the 68k/VDP bus cycle.
- It generates the external DTACK for the SRAM window.

Parameters:
- SRAM_BASE, 23'h100000: word address of the SRAM window base (byte 0x200000).
- SRAM_WORDS_LOG2, 15: SRAM window size, 2^n words.
- SRAM_EN, 1: 0 makes all writes ignored and never asserts ext_dtack.

Ports:
- MCLK2  in  1  board clock; all logic on posedge.
- ext_reset  in  1  synchronous, active-high reset.
- cart_address  in  23  68k word address (A23:A1).
- cart_cs  in  1  cart chip select, active-high.
- cart_oe  in  1  read strobe, active-high.
- cart_lwr  in  1  low-byte write strobe, active-high.
- cart_uwr  in  1  high-byte write strobe, active-high.
- cart_data_wr  in  16  write data.
- cart_data  out  16  read data.
- cart_data_en  out  1  read data valid; board drives the bus when high.
- ext_dtack  out  1  high forces board DTACK asserted.
- mem_req  out  1  memory request, level, held until mem_ack.
- mem_we  out  1  1 = write request.
- mem_addr  out  23  word address.
- mem_be  out  2  byte enables {upper, lower}.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  16  read data, valid with mem_ack.

Behaviour:
- Reset state: all outputs 0; state IDLE; cache invalid; pf_valid 0. Reset mid-transfer drops mem_req immediately, and later acks are ignored. External memory must tolerate an abandoned request.
- Strobe detection: rd_start = rising edge of (cart_cs & cart_oe). wr_start = rising edge of (cart_cs & (cart_lwr | cart_uwr)). Both are registered one cycle.
- Request stability: mem_addr, mem_we, mem_be and mem_wdata are stable while mem_req is high. mem_req falls the cycle after mem_ack.
- IDLE, rd_start:
  - Hit when address equals cache_addr with cache valid, or equals pf_addr with pf_valid. A pf hit promotes the prefetch word into the cache.
  - Hit: cart_data and cart_data_en=1 next cycle, i.e. 2 cycles after the strobe edge. Go to RD_HOLD.
  - Miss: go to RD_MISS.
- RD_MISS: mem_req=1, mem_we=0, mem_be=2'b11. On mem_ack, load cache, drive cart_data_en=1 next cycle, go to RD_HOLD.
- RD_HOLD: cart_data_en stays 1 while cart_cs & cart_oe. On their fall, cart_data_en=0 the same registered cycle, then go to IDLE (or PF_REQ, see Optional Feature).
- IDLE, wr_start: latch address, data, be={cart_uwr, cart_lwr}.
  - Outside the SRAM window, or SRAM_EN=0: discard and go to WR_HOLD.
  - Otherwise go to WR_REQ: mem_req with mem_we=1. On ack, patch the cache/prefetch word bytes if the address matches, go to WR_HOLD.
- WR_HOLD: wait until strobes fall, then go to IDLE.
- Byte strobe widening: a second byte strobe rising while the first is still high within 1 cycle is merged into be before the request issues.
- SRAM window: cart_address[22:SRAM_WORDS_LOG2] == SRAM_BASE[22:SRAM_WORDS_LOG2].
- ext_dtack: 1 for SRAM-window accesses only. Reads: while cart_data_en. Writes: from mem_ack until strobes fall. Otherwise 0.
- Simultaneous rd_start and wr_start: write wins; the read is ignored.
- Strobe falls before the miss ack: the request completes and the cache loads, but cart_data_en stays 0.
- Address wrap: prefetch of 23'h7fffff targets 23'h000000.

Optional Feature:
- Macro: MD_CART_PREFETCH_EN.
- Defined: after RD_HOLD on a non-SRAM address A, state PF_REQ issues a read of A+1.
  - On ack: pf_addr=A+1, pf_valid=1.
  - A rd_start arriving during PF_REQ is held pending (registered), then evaluated after the ack as in IDLE.
  - A write to pf_addr invalidates or patches pf.
- Undefined: PF_REQ and the pf registers are absent; pf_valid is constant 0.

Decomposition:
- Package md_cart_pkg: state enum (IDLE, RD_MISS, RD_HOLD, WR_REQ, WR_HOLD, PF_REQ) and the cache-entry struct (addr, data, valid).
- One sub-module, md_cart_edge: registered rising-edge detector for the rd and wr strobe combinations.

Test Plan:
- Cold read, addr 23'h000100, mem_ack 5 cycles after mem_req with data 16'hA55A: cart_data=16'hA55A, cart_data_en rises the cycle after ack; ext_dtack stays 0.
- Repeat read of 23'h000100: no mem_req; cart_data_en=1 two cycles after the strobe edge.
- With MD_CART_PREFETCH_EN, sequential reads at 23'h000100 then 23'h000101 (prefetched data 16'h1234): second read produces no mem_req and returns 16'h1234.
- SRAM write at 23'h100004, lwr only, data 16'hBEEF: mem_we=1, mem_be=2'b01, mem_wdata=16'hBEEF; ext_dtack=1 from ack until strobe falls.
- ROM write at 23'h000010: no mem_req; ext_dtack stays 0.
- ext_reset asserted while in RD_MISS: mem_req=0 next cycle, all outputs 0, cache invalid; a following read of the same address misses.
